mm_ctrl_regs: RTL and testbench

//  AXI4-Lite register slave and job sequencer for the 2xK matrix compute engine.

---
 rtl/mm_ctrl_pkg.sv | 30 +++
 rtl/mm_ctrl_regs_axil_reg_port.sv | 128 ++++++++++++
 rtl/mm_ctrl_regs.sv | 184 ++++++++++++++++++
 tb/tb_mm_ctrl_regs.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_ctrl_pkg.sv
// Shared register map, response codes and job-sequencer states for the matrix-engine control slave.
package mm_ctrl_pkg;

    localparam logic [3:0] CTRL_OFS   = 4'h0;
    localparam logic [3:0] STATUS_OFS = 4'h4;
    localparam logic [3:0] CFG_K_OFS  = 4'h8;
    localparam logic [3:0] ID_OFS     = 4'hC;

    localparam int unsigned CTRL_START_BIT  = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;
    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_DONE_BIT = 1;
    localparam int unsigned STATUS_ERR_BIT  = 2;

    localparam logic [31:0] ID_VALUE  = 32'h4D4D_0001;
    localparam logic [15:0] CFG_K_RST = 16'd1;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH,
        WAIT_CLR
    } ctrl_state_t;

endpackage

// File: rtl/mm_ctrl_regs_axil_reg_port.sv
// AXI4-Lite slave handshake layer: holds AW/W until both arrive, issues one register
// access strobe per transaction and keeps B/R responses stable until accepted.
module axil_reg_port
    import mm_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] s_axil_awaddr,
    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [DATA_W-1:0] s_axil_wdata,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    output logic [1:0]        s_axil_bresp,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    input  logic [ADDR_W-1:0] s_axil_araddr,
    input  logic              s_axil_arvalid,
    output logic              s_axil_arready,
    output logic [DATA_W-1:0] s_axil_rdata,
    output logic [1:0]        s_axil_rresp,
    output logic              s_axil_rvalid,
    input  logic              s_axil_rready,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    input  logic              wr_err_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              rd_err_i
);

    logic              init_q, init_d;
    logic              aw_held_q, aw_held_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic              w_held_q, w_held_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              bvalid_q, bvalid_d;
    resp_t             bresp_q, bresp_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    resp_t             rresp_q, rresp_d;

    // init_q keeps every ready low while in reset and for the first cycle after release
    assign s_axil_awready = init_q & ~aw_held_q & ~bvalid_q;
    assign s_axil_wready  = init_q & ~w_held_q & ~bvalid_q;
    assign s_axil_arready = init_q & ~rvalid_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;

    assign wr_en_o   = aw_held_q & w_held_q;
    assign wr_addr_o = awaddr_q;
    assign wr_data_o = wdata_q;
    assign rd_en_o   = s_axil_arvalid & s_axil_arready;
    assign rd_addr_o = s_axil_araddr;

    always_comb begin
        init_d    = 1'b1;
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        if (s_axil_awvalid && s_axil_awready) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_axil_awaddr;
        end
        if (s_axil_wvalid && s_axil_wready) begin
            w_held_d = 1'b1;
            wdata_d  = s_axil_wdata;
        end
        if (wr_en_o) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_err_i ? SLVERR : OKAY;
        end else if (bvalid_q && s_axil_bready) begin
            bvalid_d = 1'b0;
        end

        if (rd_en_o) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data_i;
            rresp_d  = rd_err_i ? SLVERR : OKAY;
        end else if (rvalid_q && s_axil_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q    <= 1'b0;
            aw_held_q <= 1'b0;
            awaddr_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            init_q    <= init_d;
            aw_held_q <= aw_held_d;
            awaddr_q  <= awaddr_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

endmodule

// File: rtl/mm_ctrl_regs.sv
// Control/status register file and job sequencer for the 2xK matrix engine,
// reached through an AXI4-Lite slave port.
module mm_ctrl_regs
    import mm_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned K_MAX  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] s_axil_awaddr,
    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [DATA_W-1:0] s_axil_wdata,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    output logic [1:0]        s_axil_bresp,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    input  logic [ADDR_W-1:0] s_axil_araddr,
    input  logic              s_axil_arvalid,
    output logic              s_axil_arready,
    output logic [DATA_W-1:0] s_axil_rdata,
    output logic [1:0]        s_axil_rresp,
    output logic              s_axil_rvalid,
    input  logic              s_axil_rready,
    output logic              core_start_o,
    output logic [15:0]       core_cfg_k_o,
    input  logic              core_done_i,
    output logic              core_clr_done_o,
    output logic              irq_o
);

    logic              wr_en, wr_err, wr_hit;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en, rd_err, rd_hit;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    ctrl_state_t state_q, state_d;
    logic [15:0] cfg_k_q, cfg_k_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        irq_q;
    logic        busy, start_req;

    axil_reg_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .wr_en_o        (wr_en),
        .wr_addr_o      (wr_addr),
        .wr_data_o      (wr_data),
        .wr_err_i       (wr_err),
        .rd_en_o        (rd_en),
        .rd_addr_o      (rd_addr),
        .rd_data_i      (rd_data),
        .rd_err_i       (rd_err)
    );

    assign busy   = (state_q != IDLE);
    assign wr_hit = (wr_addr[1:0] == 2'b00) && (wr_addr[ADDR_W-1:4] == '0);
    assign rd_hit = (rd_addr[1:0] == 2'b00) && (rd_addr[ADDR_W-1:4] == '0);

    always_comb begin
        state_d   = state_q;
        cfg_k_d   = cfg_k_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        err_d     = err_q;
        wr_err    = 1'b0;
        start_req = 1'b0;

        if (wr_en) begin
            if (!wr_hit) begin
                wr_err = 1'b1;
            end else begin
                case (wr_addr[3:0])
                    CTRL_OFS: begin
                        irq_en_d = wr_data[CTRL_IRQ_EN_BIT];
                        if (wr_data[CTRL_START_BIT]) begin
                            if (busy) err_d = 1'b1;
                            else      start_req = 1'b1;
                        end
                    end
                    STATUS_OFS: begin
                        if (wr_data[STATUS_DONE_BIT]) done_d = 1'b0;
                        if (wr_data[STATUS_ERR_BIT])  err_d  = 1'b0;
                    end
                    CFG_K_OFS: begin
                        if (busy) begin
                            err_d  = 1'b1;
                            wr_err = 1'b1;
                        end else if (wr_data == '0 || wr_data > DATA_W'(K_MAX)) begin
                            wr_err = 1'b1;
                        end else begin
                            cfg_k_d = wr_data[15:0];
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Evaluated after the register writes so a FINISH set of DONE beats a same-cycle W1C
        case (state_q)
            IDLE:     if (start_req) state_d = RUN;
            RUN:      if (core_done_i) state_d = FINISH;
            FINISH: begin
                state_d = WAIT_CLR;
                done_d  = 1'b1;
            end
            WAIT_CLR: if (!core_done_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if (rd_en) begin
            if (!rd_hit) begin
                rd_err = 1'b1;
            end else begin
                case (rd_addr[3:0])
                    CTRL_OFS:   rd_data[CTRL_IRQ_EN_BIT] = irq_en_q;
                    STATUS_OFS: begin
                        rd_data[STATUS_BUSY_BIT] = busy;
                        rd_data[STATUS_DONE_BIT] = done_q;
                        rd_data[STATUS_ERR_BIT]  = err_q;
                    end
                    CFG_K_OFS:  rd_data[15:0] = cfg_k_q;
                    ID_OFS:     rd_data = DATA_W'(ID_VALUE);
                    default:    rd_err = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cfg_k_q  <= CFG_K_RST;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_k_q  <= cfg_k_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            irq_q    <= done_q & irq_en_q;
        end
    end

    assign core_start_o    = (state_q == RUN);
    assign core_clr_done_o = (state_q == FINISH);
    assign core_cfg_k_o    = cfg_k_q;
    assign irq_o           = irq_q;

endmodule

// File: tb/tb_mm_ctrl_regs.sv
// Self-checking bench for mm_ctrl_regs: directed register table, job sequences with a
// modelled engine, handshake corner cases and a randomized run against a register-map model.
module tb_mm_ctrl_regs;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int K_MAX  = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [DATA_W-1:0] wdata, rdata;
    logic [1:0]        bresp, rresp;
    logic              core_start_o, core_clr_done_o, irq_o, core_done_i;
    logic [15:0]       core_cfg_k_o;

    always #5 clk = ~clk;

    mm_ctrl_regs #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .K_MAX  (K_MAX)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axil_awaddr   (awaddr),
        .s_axil_awvalid  (awvalid),
        .s_axil_awready  (awready),
        .s_axil_wdata    (wdata),
        .s_axil_wvalid   (wvalid),
        .s_axil_wready   (wready),
        .s_axil_bresp    (bresp),
        .s_axil_bvalid   (bvalid),
        .s_axil_bready   (bready),
        .s_axil_araddr   (araddr),
        .s_axil_arvalid  (arvalid),
        .s_axil_arready  (arready),
        .s_axil_rdata    (rdata),
        .s_axil_rresp    (rresp),
        .s_axil_rvalid   (rvalid),
        .s_axil_rready   (rready),
        .core_start_o    (core_start_o),
        .core_cfg_k_o    (core_cfg_k_o),
        .core_done_i     (core_done_i),
        .core_clr_done_o (core_clr_done_o),
        .irq_o           (irq_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Engine model: raises sticky done eng_delay cycles into a job, clears it on clr pulse
    int   eng_delay = 20;
    int   eng_cnt;
    logic eng_done;
    logic eng_manual = 1'b0;
    logic man_done = 1'b0;
    assign core_done_i = eng_manual ? man_done : eng_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_done <= 1'b0;
            eng_cnt  <= 0;
        end else if (core_clr_done_o) begin
            eng_done <= 1'b0;
            eng_cnt  <= 0;
        end else if (core_start_o && !eng_done) begin
            eng_cnt <= eng_cnt + 1;
            if (eng_cnt + 1 >= eng_delay) eng_done <= 1'b1;
        end
    end

    int   start_rises = 0, start_cycles = 0, clr_cycles = 0, overlap = 0;
    logic start_prev = 1'b0;
    always @(negedge clk) begin
        if (core_start_o && !start_prev) start_rises++;
        start_prev = core_start_o;
        if (core_start_o) start_cycles++;
        if (core_clr_done_o) clr_cycles++;
        if (core_start_o && core_clr_done_o) overlap++;
    end

    task automatic axi_write_x(input logic [7:0] a, input logic [31:0] d, input int aw_dly,
                               input int w_dly, input int b_dly, output logic [1:0] resp);
        int cyc = 0;
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        resp = 2'bxx;
        while (!(aw_done && w_done) && cyc < 64) begin
            if (!aw_done && cyc == aw_dly) begin awaddr = a; awvalid = 1'b1; end
            if (!w_done && cyc == w_dly) begin wdata = d; wvalid = 1'b1; end
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(negedge clk);
            cyc++;
            if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  wvalid = 1'b0; end
        end
        while (!bvalid && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 64) begin
            awvalid = 1'b0;
            wvalid  = 1'b0;
            check("write_timeout", 32'd0, 32'd1);
            return;
        end
        resp = bresp;
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk);
            check("bvalid_hold", 32'(bvalid), 32'd1);
            check("bresp_hold", 32'(bresp), 32'(resp));
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, output logic [1:0] resp);
        axi_write_x(a, d, 0, 0, 0, resp);
    endtask

    task automatic axi_read_x(input logic [7:0] a, input int r_dly,
                              output logic [31:0] data, output logic [1:0] resp);
        int cyc = 0;
        bit hs;
        data = 'x;
        resp = 2'bxx;
        araddr  = a;
        arvalid = 1'b1;
        while (cyc < 64) begin
            hs = arvalid && arready;
            @(negedge clk);
            cyc++;
            if (hs) break;
        end
        arvalid = 1'b0;
        while (!rvalid && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 64) begin
            check("read_timeout", 32'd0, 32'd1);
            return;
        end
        data = rdata;
        resp = rresp;
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            check("rvalid_hold", 32'(rvalid), 32'd1);
            check("rdata_hold", rdata, data);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [7:0] a, input logic [31:0] exp_d,
                            input logic [1:0] exp_r);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read_x(a, 0, d, r);
        check({name, "_rdata"}, d, exp_d);
        check({name, "_rresp"}, 32'(r), 32'(exp_r));
    endtask

    task automatic wr_check(input string name, input logic [7:0] a, input logic [31:0] d,
                            input logic [1:0] exp_r);
        logic [1:0] r;
        axi_write(a, d, r);
        check({name, "_bresp"}, 32'(r), 32'(exp_r));
    endtask

    task automatic wait_job_end(input string name, input int clr0);
        int cyc = 0;
        while (clr_cycles == clr0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_finish_seen"}, 32'(clr_cycles != clr0), 32'd1);
    endtask

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl[$];

    // Register-map model for the randomized phase
    int   m_cfg, in_job;
    logic m_irq, m_done, m_err, m_busy;

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, output logic [1:0] r);
        r = 2'b00;
        if (a[1:0] != 2'b00 || a > 8'h0C) begin
            r = 2'b10;
        end else if (a == 8'h00) begin
            m_irq = d[1];
            if (d[0]) begin
                if (m_busy) m_err = 1'b1;
                else begin m_busy = 1'b1; in_job = 0; end
            end
        end else if (a == 8'h04) begin
            if (d[1]) m_done = 1'b0;
            if (d[2]) m_err = 1'b0;
        end else if (a == 8'h08) begin
            if (m_busy) begin m_err = 1'b1; r = 2'b10; end
            else if (d == 0 || d > K_MAX) r = 2'b10;
            else m_cfg = int'(d);
        end
    endtask

    task automatic model_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        d = 0;
        r = 2'b00;
        if (a[1:0] != 2'b00 || a > 8'h0C) r = 2'b10;
        else if (a == 8'h00) d = {30'd0, m_irq, 1'b0};
        else if (a == 8'h04) d = {29'd0, m_err, m_done, m_busy};
        else if (a == 8'h08) d = 32'(m_cfg);
        else d = 32'h4D4D_0001;
    endtask

    initial begin
        logic [1:0]  r;
        logic [31:0] d, ed;
        logic [1:0]  er;
        logic [7:0]  addrs [8];
        logic [7:0]  a;
        int c0, clr0, sc0;

        awaddr = '0; awvalid = 0; wdata = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(awready), 0);
        check("rst_wready", 32'(wready), 0);
        check("rst_arready", 32'(arready), 0);
        check("rst_bvalid", 32'(bvalid), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_bresp", 32'(bresp), 0);
        check("rst_rresp", 32'(rresp), 0);
        check("rst_rdata", rdata, 0);
        check("rst_start", 32'(core_start_o), 0);
        check("rst_clr", 32'(core_clr_done_o), 0);
        check("rst_irq", 32'(irq_o), 0);
        check("rst_cfg_k", 32'(core_cfg_k_o), 1);
        rst_n = 1'b1;
        @(negedge clk);

        tbl.push_back('{1'b0, 8'h0C, 32'h0,         2'b00, 32'h4D4D_0001});
        tbl.push_back('{1'b0, 8'h08, 32'h0,         2'b00, 32'd1});
        tbl.push_back('{1'b0, 8'h00, 32'h0,         2'b00, 32'd0});
        tbl.push_back('{1'b0, 8'h04, 32'h0,         2'b00, 32'd0});
        tbl.push_back('{1'b0, 8'h10, 32'h0,         2'b10, 32'd0});
        tbl.push_back('{1'b0, 8'h02, 32'h0,         2'b10, 32'd0});
        tbl.push_back('{1'b0, 8'h80, 32'h0,         2'b10, 32'd0});
        tbl.push_back('{1'b1, 8'h08, 32'd8,         2'b00, 32'd0});
        tbl.push_back('{1'b0, 8'h08, 32'h0,         2'b00, 32'd8});
        tbl.push_back('{1'b1, 8'h08, 32'd0,         2'b10, 32'd0});
        tbl.push_back('{1'b1, 8'h08, 32'd65,        2'b10, 32'd0});
        tbl.push_back('{1'b0, 8'h08, 32'h0,         2'b00, 32'd8});
        tbl.push_back('{1'b1, 8'h08, 32'd64,        2'b00, 32'd0});
        tbl.push_back('{1'b0, 8'h08, 32'h0,         2'b00, 32'd64});
        tbl.push_back('{1'b1, 8'h08, 32'hFFFF_0008, 2'b10, 32'd0});
        tbl.push_back('{1'b1, 8'h08, 32'd8,         2'b00, 32'd0});
        tbl.push_back('{1'b1, 8'h14, 32'd1,         2'b10, 32'd0});
        tbl.push_back('{1'b1, 8'h01, 32'd3,         2'b10, 32'd0});
        tbl.push_back('{1'b0, 8'h00, 32'h0,         2'b00, 32'd0});
        tbl.push_back('{1'b0, 8'h04, 32'h0,         2'b00, 32'd0});
        tbl.push_back('{1'b1, 8'h00, 32'd2,         2'b00, 32'd0});
        tbl.push_back('{1'b0, 8'h00, 32'h0,         2'b00, 32'd2});
        tbl.push_back('{1'b1, 8'h00, 32'd0,         2'b00, 32'd0});
        tbl.push_back('{1'b0, 8'h00, 32'h0,         2'b00, 32'd0});
        tbl.push_back('{1'b0, 8'h08, 32'h0,         2'b00, 32'd8});
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].wr) begin
                axi_write(tbl[i].addr, tbl[i].data, r);
                check($sformatf("vec%0d_bresp", i), 32'(r), 32'(tbl[i].resp));
            end else begin
                axi_read_x(tbl[i].addr, 0, d, r);
                check($sformatf("vec%0d_rdata", i), d, tbl[i].rdata);
                check($sformatf("vec%0d_rresp", i), 32'(r), 32'(tbl[i].resp));
            end
        end
        check("vec_no_job", 32'(start_rises), 0);

        // Job with IRQ enabled
        eng_delay = 20;
        c0 = start_rises; clr0 = clr_cycles; sc0 = start_cycles;
        wr_check("job_ctrl", 8'h00, 32'h3, 2'b00);
        check("job_start_high", 32'(core_start_o), 1);
        check("job_cfg_k_o", 32'(core_cfg_k_o), 8);
        wait_job_end("job", clr0);
        check("job_start_low_at_finish", 32'(core_start_o), 0);
        repeat (3) @(negedge clk);
        check("job_start_cycles", 32'(start_cycles - sc0), 32'(eng_delay + 1));
        check("job_clr_pulses", 32'(clr_cycles - clr0), 1);
        check("job_count", 32'(start_rises - c0), 1);
        rd_check("job_status", 8'h04, 32'h2, 2'b00);
        check("job_irq", 32'(irq_o), 1);

        // DONE clear and CFG_K range errors
        wr_check("w1c_done", 8'h04, 32'h2, 2'b00);
        check("w1c_irq_low", 32'(irq_o), 0);
        rd_check("w1c_status", 8'h04, 32'h0, 2'b00);
        wr_check("cfg_zero", 8'h08, 32'd0, 2'b10);
        wr_check("cfg_65", 8'h08, 32'd65, 2'b10);
        rd_check("cfg_keep", 8'h08, 32'd8, 2'b00);

        // Writes while busy
        eng_delay = 60;
        c0 = start_rises; clr0 = clr_cycles;
        wr_check("busy_job", 8'h00, 32'h1, 2'b00);
        wr_check("busy_start", 8'h00, 32'h1, 2'b00);
        wr_check("busy_cfg", 8'h08, 32'd4, 2'b10);
        rd_check("busy_cfg_rd", 8'h08, 32'd8, 2'b00);
        check("busy_cfg_k_o", 32'(core_cfg_k_o), 8);
        rd_check("busy_status", 8'h04, 32'h5, 2'b00);
        wait_job_end("busy", clr0);
        repeat (3) @(negedge clk);
        check("busy_one_job", 32'(start_rises - c0), 1);
        rd_check("busy_status_end", 8'h04, 32'h6, 2'b00);
        wr_check("busy_clr", 8'h04, 32'h6, 2'b00);
        rd_check("busy_status_clr", 8'h04, 32'h0, 2'b00);

        // Channel ordering and back-pressure
        axi_write_x(8'h08, 32'd5, 0, 3, 5, r);
        check("aw_first_bresp", 32'(r), 0);
        check("aw_first_bdone", 32'(bvalid), 0);
        rd_check("aw_first_rd", 8'h08, 32'd5, 2'b00);
        axi_write_x(8'h08, 32'd6, 3, 0, 0, r);
        check("w_first_bresp", 32'(r), 0);
        rd_check("w_first_rd", 8'h08, 32'd6, 2'b00);
        axi_write_x(8'h08, 32'd7, 2, 2, 2, r);
        check("same_bresp", 32'(r), 0);
        rd_check("same_rd", 8'h08, 32'd7, 2'b00);
        axi_write_x(8'h08, 32'd0, 1, 0, 5, r);
        check("err_hold_bresp", 32'(r), 2);
        rd_check("err_hold_rd", 8'h08, 32'd7, 2'b00);
        axi_read_x(8'h0C, 4, d, r);
        check("rhold_id", d, 32'h4D4D_0001);
        check("rhold_resp", 32'(r), 0);

        // Reset mid-job
        eng_delay = 60;
        wr_check("rst_cfg", 8'h08, 32'd9, 2'b00);
        wr_check("rst_job", 8'h00, 32'h3, 2'b00);
        repeat (5) @(negedge clk);
        check("rst_job_running", 32'(core_start_o), 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_start", 32'(core_start_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst2_cfg_k_o", 32'(core_cfg_k_o), 1);
        check("rst2_irq", 32'(irq_o), 0);
        rd_check("rst2_cfg", 8'h08, 32'd1, 2'b00);
        rd_check("rst2_ctrl", 8'h00, 32'd0, 2'b00);
        rd_check("rst2_status", 8'h04, 32'd0, 2'b00);

        // W1C of DONE landing in the FINISH cycle
        eng_manual = 1'b1;
        man_done = 1'b0;
        wr_check("fin_job", 8'h00, 32'h1, 2'b00);
        repeat (2) @(negedge clk);
        check("fin_awready", 32'(awready), 1);
        check("fin_wready", 32'(wready), 1);
        awaddr = 8'h04; wdata = 32'h2; awvalid = 1'b1; wvalid = 1'b1; man_done = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("fin_clr_pulse", 32'(core_clr_done_o), 1);
        man_done = 1'b0;
        @(negedge clk);
        check("fin_bvalid", 32'(bvalid), 1);
        check("fin_bresp", 32'(bresp), 0);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        rd_check("fin_status", 8'h04, 32'h2, 2'b00);
        eng_manual = 1'b0;

        // Randomized traffic against the register-map model
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        eng_delay = 200;
        m_cfg = 1; m_irq = 0; m_done = 0; m_err = 0; m_busy = 0; in_job = 0;
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h02, 8'h40, 8'h0D};
        for (int it = 0; it < 80; it++) begin
            a = addrs[$urandom_range(0, 7)];
            if (a == 8'h08 && $urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 70));
            else d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                model_write(a, d, er);
                axi_write(a, d, r);
                check($sformatf("rnd%0d_bresp", it), 32'(r), 32'(er));
            end else begin
                model_read(a, ed, er);
                axi_read_x(a, 0, d, r);
                check($sformatf("rnd%0d_rdata", it), d, ed);
                check($sformatf("rnd%0d_rresp", it), 32'(r), 32'(er));
            end
            check($sformatf("rnd%0d_cfg_k_o", it), 32'(core_cfg_k_o), 32'(m_cfg));
            check($sformatf("rnd%0d_irq", it), 32'(irq_o), 32'(m_done & m_irq));
            check($sformatf("rnd%0d_start", it), 32'(core_start_o), 32'(m_busy));
            if (m_busy) begin
                in_job++;
                if (in_job >= 6) begin
                    repeat (300) @(negedge clk);
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    in_job = 0;
                    check($sformatf("rnd%0d_irq_after_job", it), 32'(irq_o), 32'(m_irq));
                end
            end
        end

        check("start_clr_overlap", 32'(overlap), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
